// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite bus types and response codes.
package axi4l_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [1:0]  resp_t;
  typedef logic [3:0]  strb_t;
  typedef logic [2:0]  prot_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;
  localparam resp_t DECERR = 2'b11;
endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite channel bundle with initiator (master) and responder (slave) views.
interface axi4l_if;
  import axi4l_pkg::*;

  logic  awvalid, awready;
  addr_t awaddr;
  prot_t awprot;
  logic  wvalid, wready;
  data_t wdata;
  strb_t wstrb;
  logic  bvalid, bready;
  resp_t bresp;
  logic  arvalid, arready;
  addr_t araddr;
  prot_t arprot;
  logic  rvalid, rready;
  data_t rdata;
  resp_t rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input  bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input  rvalid, rdata, rresp, output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot, output awready,
    input  wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input  arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/axi4l_host_bridge.sv
// Single-outstanding host req/gnt to AXI4-Lite initiator bridge.
// Optional transaction timeout with orphan drain: define AXI4L_TIMEOUT_EN.
module axi4l_host_bridge
  import axi4l_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic    aclk,
  input  logic    areset,
  input  logic    data_req_i,
  output logic    data_gnt_o,
  output logic    data_rvalid_o,
  input  logic    data_we_i,
  input  strb_t   data_be_i,
  input  addr_t   data_addr_i,
  input  data_t   data_wdata_i,
  output data_t   data_rdata_o,
  output logic    data_err_o,
  axi4l_if.master axi
);

`ifdef AXI4L_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_BRESP, ST_RADDR, ST_RDATA, ST_ORPHAN
  } state_e;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_BRESP, ST_RADDR, ST_RDATA
  } state_e;
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  state_e state_q, state_d;
  addr_t  addr_q, addr_d;
  data_t  wdata_q, wdata_d;
  strb_t  be_q, be_d;
  logic   we_q, we_d;
  logic   awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic   rvalid_q, rvalid_d, err_q, err_d;
  data_t  rdata_q, rdata_d;
  logic   bready_s, rready_s;
  logic   unused_resp_lsb;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef AXI4L_TIMEOUT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    // valids fall only on their own handshake, regardless of state changes
    awvalid_d  = awvalid_q && !axi.awready;
    wvalid_d   = wvalid_q && !axi.wready;
    arvalid_d  = arvalid_q && !axi.arready;
    rvalid_d   = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    data_gnt_o = data_req_i && (state_q == ST_IDLE);
    bready_s   = (state_q == ST_BRESP);
    rready_s   = (state_q == ST_RDATA);
`ifdef AXI4L_TIMEOUT_EN
    cnt_d      = cnt_q;
    if (state_q == ST_ORPHAN) begin
      bready_s = we_q && !awvalid_q && !wvalid_q;
      rready_s = !we_q && !arvalid_q;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (data_gnt_o) begin
          addr_d  = data_addr_i;
          wdata_d = data_wdata_i;
          be_d    = data_be_i;
          we_d    = data_we_i;
          if (data_we_i) begin
            state_d   = ST_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WRITE: if (!awvalid_d && !wvalid_d) state_d = ST_BRESP;
      ST_BRESP: begin
        if (axi.bvalid) begin
          rvalid_d = 1'b1;
          err_d    = axi.bresp[1];
          rdata_d  = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_RADDR: if (axi.arready) state_d = ST_RDATA;
      ST_RDATA: begin
        if (axi.rvalid) begin
          rvalid_d = 1'b1;
          err_d    = axi.rresp[1];
          rdata_d  = axi.rdata;
          state_d  = ST_IDLE;
        end
      end
`ifdef AXI4L_TIMEOUT_EN
      ST_ORPHAN: begin
        if ((bready_s && axi.bvalid) || (rready_s && axi.rvalid)) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef AXI4L_TIMEOUT_EN
    // cnt_q holds the number of busy cycles including the current one
    if (state_q == ST_IDLE) begin
      cnt_d = data_gnt_o ? CW'(1) : '0;
    end else if (state_q == ST_ORPHAN || state_d == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q >= CW'(TIMEOUT_CYCLES - 1)) begin
      rvalid_d = 1'b1;
      err_d    = 1'b1;
      rdata_d  = '0;
      state_d  = ST_ORPHAN;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
`endif
  end

  assign axi.awvalid   = awvalid_q;
  assign axi.awaddr    = addr_q;
  assign axi.awprot    = 3'b000;
  assign axi.wvalid    = wvalid_q;
  assign axi.wdata     = wdata_q;
  assign axi.wstrb     = be_q;
  assign axi.bready    = bready_s;
  assign axi.arvalid   = arvalid_q;
  assign axi.araddr    = addr_q;
  assign axi.arprot    = 3'b000;
  assign axi.rready    = rready_s;
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;
  assign unused_resp_lsb = axi.bresp[0] ^ axi.rresp[0];

endmodule
